// File: rtl/demux2_8_buf.sv
// rtl/demux2_8_buf.sv - registered 1-to-2 byte demultiplexer with per-channel FWFT FIFOs
module demux2_8_buf #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem0 [DEPTH];
  logic [WIDTH-1:0] r_mem1 [DEPTH];
  logic [AW-1:0]    r_wptr0, r_rptr0;
  logic [AW-1:0]    r_wptr1, r_rptr1;
  logic [CW-1:0]    r_cnt0, r_cnt1;

  logic w_push0, w_push1, w_pop0, w_pop1;

  // Readiness looks only at the selected channel so one full lane never stalls the other.
  assign in_ready = in_sel ? (r_cnt1 != FULL) : (r_cnt0 != FULL);

  assign w_push0 = in_valid & in_ready & ~in_sel;
  assign w_push1 = in_valid & in_ready &  in_sel;
  assign w_pop0  = out0_valid & out0_ready;
  assign w_pop1  = out1_valid & out1_ready;

  assign out0_valid = (r_cnt0 != '0);
  assign out1_valid = (r_cnt1 != '0);
  assign out0_data  = r_mem0[r_rptr0];
  assign out1_data  = r_mem1[r_rptr1];
  assign out0_count = r_cnt0;
  assign out1_count = r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem0[i] <= '0;
      r_wptr0 <= '0;
      r_rptr0 <= '0;
      r_cnt0  <= '0;
    end else begin
      if (w_push0) begin
        r_mem0[r_wptr0] <= in_data;
        r_wptr0         <= r_wptr0 + AW'(1);
      end
      if (w_pop0) r_rptr0 <= r_rptr0 + AW'(1);
      if (w_push0 && !w_pop0)      r_cnt0 <= r_cnt0 + CW'(1);
      else if (w_pop0 && !w_push0) r_cnt0 <= r_cnt0 - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem1[i] <= '0;
      r_wptr1 <= '0;
      r_rptr1 <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_push1) begin
        r_mem1[r_wptr1] <= in_data;
        r_wptr1         <= r_wptr1 + AW'(1);
      end
      if (w_pop1) r_rptr1 <= r_rptr1 + AW'(1);
      if (w_push1 && !w_pop1)      r_cnt1 <= r_cnt1 + CW'(1);
      else if (w_pop1 && !w_push1) r_cnt1 <= r_cnt1 - CW'(1);
    end
  end

endmodule

// File: tb/tb_demux2_8_buf.sv
// tb/tb_demux2_8_buf.sv - randomized and directed bench for demux2_8_buf against a queue model
module tb_demux2_8_buf;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk, rst_n;
  logic [7:0]    in_data;
  logic          in_sel, in_valid, in_ready;
  logic [7:0]    out0_data, out1_data;
  logic          out0_valid, out1_valid, out0_ready, out1_ready;
  logic [CW-1:0] out0_count, out1_count;

  int checks = 0;
  int errors = 0;

  byte unsigned q0[$];
  byte unsigned q1[$];
  bit m_push, m_pop0, m_pop1;

  demux2_8_buf #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: two plain queues; a push is accepted when the chosen queue is below DEPTH.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      m_push = in_valid && ((in_sel ? q1.size() : q0.size()) != DEPTH);
      m_pop0 = out0_ready && (q0.size() != 0);
      m_pop1 = out1_ready && (q1.size() != 0);
      if (m_pop0) void'(q0.pop_front());
      if (m_pop1) void'(q1.pop_front());
      if (m_push) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, ((in_sel ? q1.size() : q0.size()) != DEPTH));
      chk("out0_valid", out0_valid, q0.size() != 0);
      chk("out1_valid", out1_valid, q1.size() != 0);
      chk("out0_count", out0_count, q0.size());
      chk("out1_count", out1_count, q1.size());
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    end
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out0_count", out0_count, 0);
    chk("rst_out0_data", out0_data, 8'h00);
    chk("rst_out1_count", out1_count, 0);
    rst_n = 1'b1;

    drive(1, 0, 8'hA5, 0, 0); step();
    chk("route_out0_data", out0_data, 8'hA5);
    chk("route_out0_count", out0_count, 1);
    drive(1, 1, 8'h3C, 0, 0); step();
    chk("route_out1_data", out1_data, 8'h3C);
    chk("route_out1_count", out1_count, 1);
    drive(0, 0, 8'h00, 1, 1); step();
    drive(0, 0, 8'h00, 0, 0); step();

    drive(1, 0, 8'h11, 0, 0); step();
    drive(1, 0, 8'h22, 0, 0); step();
    chk("full_out0_count", out0_count, 2);
    drive(1, 0, 8'h55, 0, 0); #1;
    chk("full_in_ready_sel0", in_ready, 0);
    drive(1, 1, 8'h77, 0, 0); #1;
    chk("full_in_ready_sel1", in_ready, 1);
    step();
    chk("full_out1_data", out1_data, 8'h77);
    chk("full_out0_count_held", out0_count, 2);

    drive(1, 0, 8'h33, 1, 0); #1;
    chk("fullpop_in_ready", in_ready, 0);
    step();
    chk("fullpop_out0_count", out0_count, 1);
    chk("fullpop_out0_data", out0_data, 8'h22);

    drive(1, 0, 8'h44, 0, 0); step();
    chk("pre_rst_out0_count", out0_count, 2);
    drive(0, 0, 8'h00, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out0_valid", out0_valid, 0);
    chk("async_rst_out0_count", out0_count, 0);
    chk("async_rst_out0_data", out0_data, 8'h00);
    chk("async_rst_out1_count", out1_count, 0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 8'h00, 0, 0); #1;
    chk("post_rst_ready_sel0", in_ready, 1);
    drive(0, 1, 8'h00, 0, 0); #1;
    chk("post_rst_ready_sel1", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      drive(1, i[0], 8'(i), 1, 1);
      step();
      if (i[0]) begin
        chk("stream_out1_data", out1_data, i);
        chk("stream_out1_count_le1", out1_count <= 1, 1);
      end else begin
        chk("stream_out0_data", out0_data, i);
        chk("stream_out0_count_le1", out0_count <= 1, 1);
      end
    end
    drive(0, 0, 8'h00, 1, 1); step();

    drive(1, 1, 8'hC0, 0, 0); step();
    for (int k = 1; k <= 6; k++) begin
      drive(1, 1, 8'(8'hC0 + k), 0, 1);
      step();
      chk("steady_out1_count", out1_count, 1);
      chk("steady_out1_data", out1_data, 8'hC0 + k);
    end
    drive(0, 0, 8'h00, 1, 1); step();

    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = (i / 300) % 3;
      drive(($urandom % 4) != 0, $urandom % 2, 8'($urandom),
            ($urandom % 3) < rp, ($urandom % 3) < (2 - rp + 1) % 3);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      step();
    end

    drive(0, 0, 8'h00, 0, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux2_8_buf.md
Name: demux2_8_buf

Overview:
- Registered 1-to-2 byte demultiplexer: the inverse of the CPU's 8-bit 2-to-1 datapath mux.
- Accepts one 8-bit byte per cycle over a valid/ready handshake and steers it by in_sel into one of two per-channel FIFOs.
- Each output channel drains independently over its own valid/ready handshake.
- Used in the multi-cycle datapath to split memory/ALU byte results toward the low-byte and high-byte writeback consumers.

Parameters:
- WIDTH, 8, data width of every byte lane.
- DEPTH, 2, entries per output FIFO; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of occupancy counters (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  byte to route.
- in_sel  input  1  destination channel: 0 routes to out0, 1 routes to out1.
- in_valid  input  1  in_data and in_sel are valid this cycle.
- in_ready  output  1  selected channel can accept this cycle.
- out0_data  output  WIDTH  head byte of channel 0.
- out0_valid  output  1  channel 0 is non-empty.
- out0_ready  input  1  consumer takes channel 0's head this cycle.
- out1_data  output  WIDTH  head byte of channel 1.
- out1_valid  output  1  channel 1 is non-empty.
- out1_ready  input  1  consumer takes channel 1's head this cycle.
- out0_count  output  CW  channel 0 occupancy, 0..DEPTH.
- out1_count  output  CW  channel 1 occupancy, 0..DEPTH.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0:
  - all storage, read/write pointers and counts clear to 0;
  - out0_valid=out1_valid=0, out0_data=out1_data=0, out0_count=out1_count=0.
  - Reset mid-operation discards all queued bytes immediately, without waiting for a clock edge.
- in_ready: combinational; in_ready = (in_sel ? out1_count : out0_count) != DEPTH. It depends only on the selected channel, so a full channel does not block traffic to the other (no cross-channel head-of-line blocking).
- Push: in_valid & in_ready at a rising edge writes in_data to the selected FIFO's write slot and advances its write pointer mod DEPTH.
- Pop: outK_valid & outK_ready at a rising edge advances channel K's read pointer mod DEPTH.
- Output data: outK_data is driven from storage at the read pointer (first-word fall-through). A byte pushed at edge N is visible on outK_data/outK_valid after edge N, i.e. latency 1 cycle, with no input-to-output combinational path.
- Valid: outK_valid = (outK_count != 0). When the count is 0, outK_data holds the last stored value at the read pointer (don't-care to consumers, deterministic after reset).
- Count update per channel at each edge:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop, or on neither.
- Full with simultaneous pop: in_ready stays 0, so a push into a full channel is refused even in the cycle that channel pops. The byte must be re-presented; no pass-through.
- Empty with a push and outK_ready=1: no pop occurs that cycle because valid=0; the byte appears next cycle.
- Both channels can pop in the same cycle as one push; all three operations are independent.
- Wrap-around: pointers wrap DEPTH-1 → 0 with no gap; FIFO order is preserved per channel.
- in_valid=0: no state change on the input side, regardless of in_sel.
- Pop with outK_valid=0 is ignored; the count never underflows.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out0_count=2 → out0_valid=0, out0_count=0 and out0_data=8'h00 immediately, without a clock edge; after release, in_ready=1 for both selects.
- Routing: push 8'hA5 with sel=0, then 8'h3C with sel=1, outputs not ready → next cycle after each push: out0_data=8'hA5 with out0_count=1; out1_data=8'h3C with out1_count=1.
- Full/backpressure: push 8'h11 and 8'h22 into ch0 with out0_ready=0 → out0_count=2, in_ready=0 for sel=0 and 1 for sel=1; a push of 8'h77 to ch1 succeeds that cycle.
- Full + simultaneous pop: ch0 full, out0_ready=1 and in_valid=1 with sel=0 and data 8'h33 → 8'h11 pops, 8'h33 not accepted, count becomes 1, out0_data=8'h22.
- Streaming/wrap: both outputs always ready, 10 alternating pushes 8'h00..8'h09 → ch0 emits 00,02,04,06,08 and ch1 emits 01,03,05,07,09, each 1 cycle after push; counts stay ≤1; order is preserved across pointer wrap.
- Steady push+pop at count 1 on ch1 for 6 cycles → out1_count stays 1 and every byte emerges exactly one cycle after entry.
